// File: rtl/trdb_stream_arbiter_if.sv
// Stream arbiter bus: trace packet source, software dump source, flush
// control and the registered output stream toward the packet streamer.
interface trdb_stream_arbiter_if #(
    parameter int XLEN = 32
);
    // Trace packet source
    logic [XLEN-1:0] pkt_word_i;
    logic            pkt_valid_i;
    logic            pkt_last_i;
    logic            pkt_grant_o;
    // Software dump source
    logic [XLEN-1:0] sw_word_i;
    logic            sw_valid_i;
    logic            sw_grant_o;
    // Flush control
    logic            flush_i;
    logic            flush_confirm_o;
    // Output stream
    logic [XLEN-1:0] out_word_o;
    logic            out_src_o;
    logic            out_last_o;
    logic            out_valid_o;
    logic            out_ready_i;

    // Arbiter side
    modport slave (
        input  pkt_word_i, pkt_valid_i, pkt_last_i,
        output pkt_grant_o,
        input  sw_word_i, sw_valid_i,
        output sw_grant_o,
        input  flush_i,
        output flush_confirm_o,
        output out_word_o, out_src_o, out_last_o, out_valid_o,
        input  out_ready_i
    );

    // Environment side (sources, control register, streamer)
    modport master (
        output pkt_word_i, pkt_valid_i, pkt_last_i,
        input  pkt_grant_o,
        output sw_word_i, sw_valid_i,
        input  sw_grant_o,
        output flush_i,
        input  flush_confirm_o,
        input  out_word_o, out_src_o, out_last_o, out_valid_o,
        output out_ready_i
    );
endinterface

// File: rtl/trdb_stream_arbiter.sv
// Merges trace packets (priority) and software dump words into one stream.
// Multi-word packets are kept atomic, software starvation is bounded by
// SW_STARVE_LIMIT complete packets, and flushes are confirmed with a pulse
// once both sources and the output register are empty.
module trdb_stream_arbiter #(
    parameter int XLEN            = 32,
    parameter int SW_STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    trdb_stream_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PKT   = 2'd1,
        S_DRAIN = 2'd2,
        S_ACK   = 2'd3
    } state_e;

    localparam logic [7:0] STARVE_LIMIT = 8'(SW_STARVE_LIMIT);

    state_e          state_q, state_d;
    logic [7:0]      starve_cnt_q, starve_cnt_d;
    logic [XLEN-1:0] out_word_q, out_word_d;
    logic            out_src_q, out_src_d;
    logic            out_last_q, out_last_d;
    logic            out_valid_q, out_valid_d;
    logic            flush_confirm_q, flush_confirm_d;

    logic            load_en;
    logic            starve_hit;
    logic            pkt_grant;
    logic            sw_grant;

    // Output register can take a word when empty or being drained this cycle.
    assign load_en    = ~out_valid_q | bus.out_ready_i;
    assign starve_hit = bus.sw_valid_i && (starve_cnt_q == STARVE_LIMIT);

    // Arbitration and next-state logic; grants only fire when load_en is set.
    always_comb begin
        pkt_grant = 1'b0;
        sw_grant  = 1'b0;
        state_d   = state_q;
        case (state_q)
            S_IDLE, S_DRAIN: begin
                if (starve_hit) begin
                    sw_grant = load_en;
                end else if (bus.pkt_valid_i) begin
                    pkt_grant = load_en;
                    // A multi-word packet locks the output until its last word.
                    if (load_en && !bus.pkt_last_i) begin
                        state_d = S_PKT;
                    end
                end else if (bus.sw_valid_i) begin
                    sw_grant = load_en;
                end else if (state_q == S_IDLE) begin
                    if (bus.flush_i) begin
                        state_d = S_DRAIN;
                    end
                end else if (!out_valid_q || bus.out_ready_i) begin
                    // Sources idle and output empties this cycle: confirm.
                    state_d = S_ACK;
                end
            end
            S_PKT: begin
                if (bus.pkt_valid_i) begin
                    pkt_grant = load_en;
                    if (load_en && bus.pkt_last_i) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Sources must never see a grant while the block is held in reset.
        if (!rst_ni) begin
            pkt_grant = 1'b0;
            sw_grant  = 1'b0;
        end
    end

    // Count complete packets that went ahead of a waiting software word.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.sw_valid_i || sw_grant) begin
            starve_cnt_d = 8'd0;
        end else if (pkt_grant && bus.pkt_last_i && (starve_cnt_q != STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    // Output register load: granted word, or bubble when drained with no grant.
    always_comb begin
        out_word_d      = out_word_q;
        out_src_d       = out_src_q;
        out_last_d      = out_last_q;
        out_valid_d     = out_valid_q;
        flush_confirm_d = (state_d == S_ACK);
        if (load_en) begin
            out_valid_d = pkt_grant | sw_grant;
            if (pkt_grant) begin
                out_word_d = bus.pkt_word_i;
                out_src_d  = 1'b0;
                out_last_d = bus.pkt_last_i;
            end else if (sw_grant) begin
                out_word_d = bus.sw_word_i;
                out_src_d  = 1'b1;
                out_last_d = 1'b1;
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            starve_cnt_q    <= 8'd0;
            out_word_q      <= '0;
            out_src_q       <= 1'b0;
            out_last_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            flush_confirm_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            starve_cnt_q    <= starve_cnt_d;
            out_word_q      <= out_word_d;
            out_src_q       <= out_src_d;
            out_last_q      <= out_last_d;
            out_valid_q     <= out_valid_d;
            flush_confirm_q <= flush_confirm_d;
        end
    end

    assign bus.pkt_grant_o     = pkt_grant;
    assign bus.sw_grant_o      = sw_grant;
    assign bus.flush_confirm_o = flush_confirm_q;
    assign bus.out_word_o      = out_word_q;
    assign bus.out_src_o       = out_src_q;
    assign bus.out_last_o      = out_last_q;
    assign bus.out_valid_o     = out_valid_q;

endmodule
